mux_nch_reg: RTL and testbench

- Parametrised successor to the single-bit 2-input mux: CHANNELS inputs of WIDTH bits, with a registered output and a valid/ready handshake on every port.
- Two select modes, chosen at runtime:
  - Direct: the channel is named by the SEL input.
  - Round-robin: the channel is picked by a fair arbiter.
- Sits between multiple data producers (e.g. register file, ALU, immediate source) and a single consumer stage in the MCU datapath.

---
 rtl/mux_nch_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/mux_nch_reg.sv | 116 +++++++++++
 tb/tb_mux_nch_reg.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mux_nch_pkg.sv
// Shared types for the N-channel registered mux.
package mux_nch_pkg;

   typedef enum logic {
      MODE_DIRECT = 1'b0,
      MODE_RR     = 1'b1
   } mux_mode_t;

   typedef enum logic {
      ST_EMPTY,
      ST_FULL
   } mux_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester found scanning upward
// from PTR, wrapping modulo CHANNELS. Purely combinational; the pointer
// itself lives in the owner so that it only advances on real transfers.
module rr_arbiter #(
   parameter  int CHANNELS = 4,
   localparam int SEL_W    = $clog2(CHANNELS)
) (
   input  logic [CHANNELS-1:0] REQ,
   input  logic [SEL_W-1:0]    PTR,
   output logic [CHANNELS-1:0] GRANT,
   output logic [SEL_W-1:0]    GRANT_IDX,
   output logic                GRANT_VLD
);

   // priority scan starting at PTR; first hit wins
   always_comb begin
      int ci;
      ci        = 0;
      GRANT     = '0;
      GRANT_IDX = '0;
      GRANT_VLD = 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
         ci = int'(PTR) + k;
         if (ci >= CHANNELS) ci = ci - CHANNELS;
         if (!GRANT_VLD && REQ[ci]) begin
            GRANT[ci] = 1'b1;
            GRANT_IDX = SEL_W'(ci);
            GRANT_VLD = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_nch_reg.sv
// N-channel registered mux with valid/ready on every port and runtime
// choice between direct (SEL) and round-robin channel selection.
// Optional macro MUX_NCH_PARITY_EN adds OUT_PAR, the XOR of the held word.
//
// state    | meaning
// ---------+----------------------------------------------
// ST_EMPTY | output register holds nothing (OUT_VALID=0)
// ST_FULL  | output register holds a word awaiting OUT_READY
module mux_nch_reg
   import mux_nch_pkg::*;
#(
   parameter  int WIDTH    = 8,
   parameter  int CHANNELS = 4,
   localparam int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      MODE,
   input  logic [SEL_W-1:0]          SEL,
   input  logic [CHANNELS*WIDTH-1:0] IN_DATA,
   input  logic [CHANNELS-1:0]       IN_VALID,
   output logic [CHANNELS-1:0]       IN_READY,
   output logic [WIDTH-1:0]          OUT_DATA,
   output logic [SEL_W-1:0]          OUT_CH,
   output logic                      OUT_VALID,
   input  logic                      OUT_READY
`ifdef MUX_NCH_PARITY_EN
   ,
   output logic                      OUT_PAR
`endif
);

   // SEL can address past CHANNELS when CHANNELS is not a power of two;
   // padding the valid vector makes those indices read as "not valid".
   localparam int SEL_N = 1 << SEL_W;

   mux_mode_t             mode;
   mux_state_t            state;
   logic [SEL_W-1:0]      ptr;
   logic [SEL_W-1:0]      ptr_next;
   logic [SEL_N-1:0]      valid_pad;
   logic [CHANNELS-1:0]   rr_grant;
   logic [SEL_W-1:0]      rr_idx;
   logic                  rr_vld;
   logic [CHANNELS-1:0]   grant;
   logic [SEL_W-1:0]      grant_idx;
   logic                  grant_vld;
   logic                  load;
   logic                  accept;
   logic [WIDTH-1:0]      sel_data;

   assign mode = mux_mode_t'(MODE);

   rr_arbiter #(
      .CHANNELS (CHANNELS)
   ) u_rr_arbiter (
      .REQ       (IN_VALID),
      .PTR       (ptr),
      .GRANT     (rr_grant),
      .GRANT_IDX (rr_idx),
      .GRANT_VLD (rr_vld)
   );

   // pick the candidate channel for this cycle from the active mode
   always_comb begin
      valid_pad                 = '0;
      valid_pad[CHANNELS-1:0]   = IN_VALID;
      grant                     = '0;
      grant_idx                 = '0;
      grant_vld                 = 1'b0;
      if (mode == MODE_RR) begin
         grant     = rr_grant;
         grant_idx = rr_idx;
         grant_vld = rr_vld;
      end else if (valid_pad[SEL]) begin
         grant[SEL] = 1'b1;
         grant_idx  = SEL;
         grant_vld  = 1'b1;
      end
   end

   assign load      = (state == ST_EMPTY) | OUT_READY;
   assign accept    = load & grant_vld & ~RST;
   assign IN_READY  = (load & ~RST) ? grant : '0;
   assign sel_data  = IN_DATA[grant_idx*WIDTH +: WIDTH];
   assign ptr_next  = (grant_idx == SEL_W'(CHANNELS-1)) ? '0 : grant_idx + SEL_W'(1);
   assign OUT_VALID = (state == ST_FULL);

   // output register FSM; pointer advances only on round-robin transfers
   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= ST_EMPTY;
         OUT_DATA <= '0;
         OUT_CH   <= '0;
         ptr      <= '0;
      end else if (load) begin
         if (accept) begin
            state    <= ST_FULL;
            OUT_DATA <= sel_data;
            OUT_CH   <= grant_idx;
            if (mode == MODE_RR) ptr <= ptr_next;
         end else begin
            state <= ST_EMPTY;
         end
      end
   end

`ifdef MUX_NCH_PARITY_EN
   // parity travels with the data word and holds with it during stalls
   always_ff @(posedge CLK) begin
      if (RST)         OUT_PAR <= 1'b0;
      else if (accept) OUT_PAR <= ^sel_data;
   end
`endif

endmodule

// File: tb/tb_mux_nch_reg.sv
// Bench for mux_nch_reg: vector table plus hand-written corner sequences,
// outputs checked against a scoreboard queue of accepted words.
module tb_mux_nch_reg;

   logic        clk;
   logic        rst;
   logic        mode;
   logic [1:0]  sel;
   logic [31:0] in_data;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic [7:0]  out_data;
   logic [1:0]  out_ch;
   logic        out_valid;
   logic        out_ready;
`ifdef MUX_NCH_PARITY_EN
   logic        out_par;
`endif

   int n_pass = 0;
   int n_total = 0;

   typedef struct {
      logic [7:0] data;
      logic [1:0] ch;
   } exp_t;
   exp_t q[$];

   typedef struct {
      logic       rst;
      logic       mode;
      logic [1:0] sel;
      logic [3:0] valid;
      logic       oready;
      logic [3:0] exp_rdy;
   } vec_t;
   vec_t vecs[26];

   mux_nch_reg #(.WIDTH(8), .CHANNELS(4)) dut (
      .CLK       (clk),
      .RST       (rst),
      .MODE      (mode),
      .SEL       (sel),
      .IN_DATA   (in_data),
      .IN_VALID  (in_valid),
      .IN_READY  (in_ready),
      .OUT_DATA  (out_data),
      .OUT_CH    (out_ch),
      .OUT_VALID (out_valid),
      .OUT_READY (out_ready)
`ifdef MUX_NCH_PARITY_EN
      ,
      .OUT_PAR   (out_par)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h want=%0h", name, got, exp);
   endtask

   // drive one cycle, check ready, update scoreboard, check registered outputs
   task automatic apply(input logic r, input logic m, input logic [1:0] s,
                        input logic [3:0] v, input logic [31:0] d,
                        input logic ordy, input logic [3:0] exp_rdy,
                        input string tag);
      bit   pop;
      bit   push;
      exp_t e;
      rst = r; mode = m; sel = s; in_valid = v; in_data = d; out_ready = ordy;
      #1;
      chk({tag, " in_ready"}, 32'(in_ready), 32'(exp_rdy));
      pop  = (q.size() != 0) && ordy;
      push = 1'b0;
      e.data = '0;
      e.ch   = '0;
      for (int c = 0; c < 4; c++) begin
         if (exp_rdy[c]) begin
            push   = 1'b1;
            e.ch   = 2'(c);
            e.data = d[c*8 +: 8];
         end
      end
      @(posedge clk);
      #1;
      if (r) begin
         q.delete();
         chk({tag, " rst out_valid"}, 32'(out_valid), 32'd0);
         chk({tag, " rst out_data"}, 32'(out_data), 32'd0);
         chk({tag, " rst out_ch"}, 32'(out_ch), 32'd0);
`ifdef MUX_NCH_PARITY_EN
         chk({tag, " rst out_par"}, 32'(out_par), 32'd0);
`endif
      end else begin
         if (pop) void'(q.pop_front());
         if (push) q.push_back(e);
         chk({tag, " out_valid"}, 32'(out_valid), 32'(q.size() != 0));
         if (q.size() != 0) begin
            chk({tag, " out_data"}, 32'(out_data), 32'(q[0].data));
            chk({tag, " out_ch"}, 32'(out_ch), 32'(q[0].ch));
         end
      end
   endtask

   initial begin
      logic [31:0] d;
      rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; in_data = '0; out_ready = 1'b0;

      //             rst   mode  sel   valid    ordy  exp_rdy
      vecs[0]  = '{1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0000};
      vecs[1]  = '{1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0000};
      vecs[2]  = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001};
      vecs[3]  = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010};
      vecs[4]  = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100};
      vecs[5]  = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000};
      vecs[6]  = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001};
      vecs[7]  = '{1'b0, 1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000};
      vecs[8]  = '{1'b0, 1'b1, 2'd0, 4'b1001, 1'b1, 4'b0001};
      vecs[9]  = '{1'b0, 1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000};
      vecs[10] = '{1'b0, 1'b1, 2'd0, 4'b1001, 1'b1, 4'b0001};
      vecs[11] = '{1'b0, 1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100};
      vecs[12] = '{1'b0, 1'b0, 2'd1, 4'b1101, 1'b1, 4'b0000};
      vecs[13] = '{1'b0, 1'b0, 2'd3, 4'b1000, 1'b0, 4'b1000};
      vecs[14] = '{1'b0, 1'b0, 2'd0, 4'b1111, 1'b0, 4'b0000};
      vecs[15] = '{1'b0, 1'b0, 2'd0, 4'b1111, 1'b0, 4'b0000};
      vecs[16] = '{1'b0, 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001};
      vecs[17] = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010};
      vecs[18] = '{1'b0, 1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000};
      vecs[19] = '{1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0000};
      vecs[20] = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001};
      vecs[21] = '{1'b0, 1'b1, 2'd0, 4'b0100, 1'b1, 4'b0100};
      vecs[22] = '{1'b0, 1'b1, 2'd0, 4'b0000, 1'b0, 4'b0000};
      vecs[23] = '{1'b0, 1'b1, 2'd0, 4'b0011, 1'b1, 4'b0001};
      vecs[24] = '{1'b0, 1'b0, 2'd1, 4'b0010, 1'b1, 4'b0010};
      vecs[25] = '{1'b0, 1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000};

      for (int k = 0; k < 26; k++) begin
         for (int c = 0; c < 4; c++) d[c*8 +: 8] = 8'(k*16 + c + 1);
         apply(vecs[k].rst, vecs[k].mode, vecs[k].sel, vecs[k].valid, d,
               vecs[k].oready, vecs[k].exp_rdy, $sformatf("vec%0d", k));
      end

      // direct select of ch2, then a SEL pointing at an idle channel
      apply(1'b0, 1'b0, 2'd2, 4'b0100, 32'h00A5_0000, 1'b1, 4'b0100, "dir_a5");
      chk("dir_a5 literal data", 32'(out_data), 32'h0000_00A5);
      chk("dir_a5 literal ch", 32'(out_ch), 32'd2);
      apply(1'b0, 1'b0, 2'd1, 4'b0100, 32'h00A5_0000, 1'b1, 4'b0000, "dir_idle");
      chk("dir_idle valid drop", 32'(out_valid), 32'd0);

      // backpressure: 3C held through three stalled cycles, then pop+accept
      apply(1'b0, 1'b0, 2'd0, 4'b0001, 32'h0000_003C, 1'b1, 4'b0001, "bp_load");
      for (int i = 0; i < 3; i++) begin
         apply(1'b0, 1'b0, 2'd0, 4'b1111, 32'h1122_3344, 1'b0, 4'b0000,
               $sformatf("bp_stall%0d", i));
         chk("bp held data", 32'(out_data), 32'h0000_003C);
      end
      apply(1'b0, 1'b0, 2'd1, 4'b1111, 32'h0000_5A00, 1'b1, 4'b0010, "bp_release");
      chk("bp no bubble valid", 32'(out_valid), 32'd1);
      chk("bp no bubble data", 32'(out_data), 32'h0000_005A);

`ifdef MUX_NCH_PARITY_EN
      apply(1'b0, 1'b0, 2'd0, 4'b0001, 32'h0000_0003, 1'b1, 4'b0001, "par_03");
      chk("par_03 out_par", 32'(out_par), 32'd0);
      apply(1'b0, 1'b0, 2'd0, 4'b0001, 32'h0000_0007, 1'b1, 4'b0001, "par_07");
      chk("par_07 out_par", 32'(out_par), 32'd1);
      apply(1'b0, 1'b0, 2'd0, 4'b0001, 32'h0000_0003, 1'b0, 4'b0000, "par_stall");
      chk("par_stall out_par", 32'(out_par), 32'd1);
`endif

      apply(1'b0, 1'b0, 2'd0, 4'b0000, 32'h0, 1'b1, 4'b0000, "drain");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
